// File: rtl/clk_div_pkg.sv
// Shared types and constants for the parametrised clock divider.
// FSM encoding and the smallest ratio that actually divides.
package clk_div_pkg;

  typedef enum logic [1:0] {
    BYPASS = 2'd0,
    HIGH   = 2'd1,
    LOW    = 2'd2
  } state_e;

  localparam int unsigned MIN_RATIO = 2;

endpackage

// File: rtl/clk_div_phase_ctr.sv
// Phase counter for one half-period of the divided clock.
// Terminal flag fires on the last cycle of the current half.
module clk_div_phase_ctr #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_term
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_term = (cnt_q == (i_limit - ONE));

endmodule

// File: rtl/clk_div_param.sv
// Integer clock divider with boundary-only retune, resync and tick.
// Bypass mux select is registered so output switching is glitch-free.
module clk_div_param
  import clk_div_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit RST_BYPASS = 1'b1
) (
  input  logic             i_ref_clk,
  input  logic             i_rst_n,
  input  logic             i_clk_en,
  input  logic [WIDTH-1:0] i_div_ratio,
  input  logic             i_resync,
  output logic             o_div_clk,
  output logic             o_div_tick,
  output logic             o_bypass,
  output logic [WIDTH-1:0] o_ratio_active
);

  state_e           state_q, state_d;
  logic             div_q, div_d;
  logic             tick_q, tick_d;
  logic             bypass_q, bypass_d;
  logic [WIDTH-1:0] ratio_q, ratio_d;

  logic             valid;
  logic             do_start;
  logic             do_stop;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_term;
  logic [WIDTH-1:0] half_h;
  logic [WIDTH-1:0] half_l;
  logic [WIDTH-1:0] limit;

  assign valid  = i_clk_en && (i_div_ratio >= WIDTH'(MIN_RATIO));
  assign half_h = ratio_q >> 1;
  // Odd ratios give the extra cycle to the low phase.
  assign half_l = ratio_q - half_h;
  assign limit  = (state_q == HIGH) ? half_h : half_l;

  clk_div_phase_ctr #(
    .WIDTH(WIDTH)
  ) u_phase_ctr (
    .i_clk   (i_ref_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (cnt_clr),
    .i_inc   (cnt_inc),
    .i_limit (limit),
    .o_term  (cnt_term)
  );

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    tick_d   = 1'b0;
    bypass_d = bypass_q;
    ratio_d  = ratio_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    do_start = 1'b0;
    do_stop  = 1'b0;

    unique case (state_q)
      HIGH, LOW: begin
        if (!i_clk_en) begin
          do_stop = 1'b1;
        end else if (i_resync ||
                     (state_q == LOW && cnt_term)) begin
          do_start = valid;
          do_stop  = !valid;
        end else if (cnt_term) begin
          state_d = LOW;
          div_d   = 1'b0;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        do_start = valid;
        do_stop  = !valid;
      end
    endcase

    if (do_start) begin
      state_d  = HIGH;
      div_d    = 1'b1;
      tick_d   = 1'b1;
      bypass_d = 1'b0;
      ratio_d  = i_div_ratio;
      cnt_clr  = 1'b1;
    end

    if (do_stop) begin
      state_d  = BYPASS;
      div_d    = 1'b0;
      bypass_d = 1'b1;
      ratio_d  = '0;
      cnt_clr  = 1'b1;
    end
  end

  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      state_q  <= BYPASS;
      div_q    <= 1'b0;
      tick_q   <= 1'b0;
      bypass_q <= RST_BYPASS;
      ratio_q  <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      bypass_q <= bypass_d;
      ratio_q  <= ratio_d;
    end
  end

  assign o_div_clk      = bypass_q ? i_ref_clk : div_q;
  assign o_div_tick     = tick_q;
  assign o_bypass       = bypass_q;
  assign o_ratio_active = ratio_q;

endmodule

// File: tb/tb_clk_div_param.sv
// Self-checking bench: constant vector table, directed corners and
// randomized traffic against a phase-based reference model.
module tb_clk_div_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] ratio = 8'd0;
  logic       resync = 1'b0;
  logic       o_div_clk;
  logic       o_div_tick;
  logic       o_bypass;
  logic [7:0] o_ratio_active;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: running flag, ratio in effect, phase 0..R-1.
  bit m_run = 1'b0;
  int m_r = 0;
  int m_p = 0;
  bit m_tick = 1'b0;

  logic s_div_hi;

  always #5 clk = ~clk;

  clk_div_param #(
    .WIDTH(8),
    .RST_BYPASS(1'b1)
  ) dut (
    .i_ref_clk      (clk),
    .i_rst_n        (rst_n),
    .i_clk_en       (en),
    .i_div_ratio    (ratio),
    .i_resync       (resync),
    .o_div_clk      (o_div_clk),
    .o_div_tick     (o_div_tick),
    .o_bypass       (o_bypass),
    .o_ratio_active (o_ratio_active)
  );

  typedef struct {
    bit       rst_n;
    bit       en;
    bit [7:0] ratio;
    bit       resync;
    bit       tick;
    bit       byp;
    bit [7:0] ra;
    bit       div;
  } vec_t;

  vec_t tbl[26];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit e,
                            input int q, input bit s);
    bit valid;
    valid = e && (q >= 2);
    m_tick = 1'b0;
    if (!r) begin
      m_run = 1'b0;
    end else if (!m_run || !e || s || (m_p == m_r - 1)) begin
      if (m_run && !e) begin
        m_run = 1'b0;
      end else if (valid) begin
        m_run = 1'b1;
        m_r = q;
        m_p = 0;
        m_tick = 1'b1;
      end else begin
        m_run = 1'b0;
      end
    end else begin
      m_p++;
    end
  endtask

  function automatic bit model_div();
    return m_run && (m_p < m_r / 2);
  endfunction

  task automatic step(input bit r, input bit e,
                      input logic [7:0] q, input bit s);
    rst_n = r;
    en = e;
    ratio = q;
    resync = s;
    @(posedge clk);
    model_edge(r, e, int'(q), s);
    #1;
    s_div_hi = o_div_clk;
    chk("tick", o_div_tick, m_tick);
    chk("bypass", o_bypass, !m_run);
    chk("ratio_active", o_ratio_active, m_run ? m_r : 0);
    chk("div_clk_hi", o_div_clk, m_run ? model_div() : 1'b1);
    @(negedge clk);
    #1;
    chk("div_clk_lo", o_div_clk, m_run ? model_div() : 1'b0);
  endtask

  initial begin
    int hi_cnt;
    int tick_cnt;
    logic [7:0] pat;
    logic [7:0] rq;

    tbl[0]  = '{0, 1, 4, 0, 0, 1, 0, 1};
    tbl[1]  = '{1, 1, 4, 0, 1, 0, 4, 1};
    tbl[2]  = '{1, 1, 4, 0, 0, 0, 4, 1};
    tbl[3]  = '{1, 1, 4, 0, 0, 0, 4, 0};
    tbl[4]  = '{1, 1, 4, 0, 0, 0, 4, 0};
    tbl[5]  = '{1, 1, 4, 0, 1, 0, 4, 1};
    tbl[6]  = '{1, 1, 4, 0, 0, 0, 4, 1};
    tbl[7]  = '{1, 1, 4, 0, 0, 0, 4, 0};
    tbl[8]  = '{1, 1, 4, 0, 0, 0, 4, 0};
    tbl[9]  = '{1, 1, 4, 0, 1, 0, 4, 1};
    tbl[10] = '{1, 1, 7, 0, 0, 0, 4, 1};
    tbl[11] = '{1, 1, 7, 0, 0, 0, 4, 0};
    tbl[12] = '{1, 1, 7, 0, 0, 0, 4, 0};
    tbl[13] = '{1, 1, 7, 0, 1, 0, 7, 1};
    tbl[14] = '{1, 1, 7, 0, 0, 0, 7, 1};
    tbl[15] = '{1, 1, 7, 0, 0, 0, 7, 1};
    tbl[16] = '{1, 1, 7, 0, 0, 0, 7, 0};
    tbl[17] = '{1, 1, 7, 0, 0, 0, 7, 0};
    tbl[18] = '{1, 1, 7, 0, 0, 0, 7, 0};
    tbl[19] = '{1, 1, 7, 0, 0, 0, 7, 0};
    tbl[20] = '{1, 1, 7, 0, 1, 0, 7, 1};
    tbl[21] = '{1, 0, 7, 0, 0, 1, 0, 1};
    tbl[22] = '{1, 1, 7, 0, 1, 0, 7, 1};
    tbl[23] = '{0, 1, 7, 0, 0, 1, 0, 1};
    tbl[24] = '{1, 1, 1, 0, 0, 1, 0, 1};
    tbl[25] = '{1, 1, 0, 0, 0, 1, 0, 1};

    @(negedge clk);
    for (int i = 0; i < 26; i++) begin
      step(tbl[i].rst_n, tbl[i].en, tbl[i].ratio, tbl[i].resync);
      chk($sformatf("tbl%0d_tick", i), o_div_tick, tbl[i].tick);
      chk($sformatf("tbl%0d_bypass", i), o_bypass, tbl[i].byp);
      chk($sformatf("tbl%0d_ratio", i), o_ratio_active, tbl[i].ra);
      chk($sformatf("tbl%0d_div", i), s_div_hi, tbl[i].div);
    end

    // ratio 5: high 2, low 3
    step(0, 1, 5, 0);
    pat = '0;
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 5, 0);
      pat = {pat[6:0], s_div_hi};
    end
    chk("r5_pattern", pat[4:0], 5'b11000);

    // ratio 2: alternating
    step(0, 1, 2, 0);
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 2, 0);
      pat = {pat[6:0], s_div_hi};
    end
    chk("r2_pattern", pat[3:0], 4'b1010);

    // maximum ratio: 127 high, 128 low, one tick per period
    step(0, 1, 255, 0);
    hi_cnt = 0;
    tick_cnt = 0;
    for (int i = 0; i < 255; i++) begin
      step(1, 1, 255, 0);
      hi_cnt += int'(s_div_hi);
      tick_cnt += int'(o_div_tick);
    end
    chk("r255_high", hi_cnt, 127);
    chk("r255_ticks", tick_cnt, 1);
    step(1, 1, 255, 0);
    chk("r255_wrap_tick", o_div_tick, 1'b1);

    // ratio 6 -> 1 mid-period: bypass only at boundary
    step(0, 1, 6, 0);
    step(1, 1, 6, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 1, 0);
      chk("r6to1_hold", o_bypass, 1'b0);
    end
    step(1, 1, 1, 0);
    chk("r6to1_bypass", o_bypass, 1'b1);
    chk("r6to1_ratio", o_ratio_active, 8'd0);

    // resync in LOW with cnt=2 (phase 6 of 8)
    step(0, 1, 8, 0);
    step(1, 1, 8, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 8, 0);
    chk("rs_in_low", s_div_hi, 1'b0);
    step(1, 1, 8, 1);
    chk("rs_tick", o_div_tick, 1'b1);
    chk("rs_high", s_div_hi, 1'b1);
    step(1, 1, 8, 0);
    chk("rs_no_tick", o_div_tick, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rq = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255))
                                        : 8'($urandom_range(0, 12));
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 29) != 0,
           rq,
           $urandom_range(0, 39) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
